// File: rtl/ocx_afu_cmd_pkg.sv
// Shared opcodes, pull-count encodings, FSM states and the FIFO entry layout
// for the AFU command intake path.
package ocx_afu_cmd_pkg;

    localparam logic [7:0] OPC_WRITE_MEM    = 8'h81;
    localparam logic [7:0] OPC_WRITE_MEM_BE = 8'h82;
    localparam logic [7:0] OPC_PR_WR_MEM    = 8'h86;

    localparam logic [2:0] RD_CNT_1 = 3'b001;
    localparam logic [2:0] RD_CNT_2 = 3'b010;
    localparam logic [2:0] RD_CNT_4 = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESENT,
        ST_RDREQ,
        ST_DATA
    } state_e;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [1:0]  dl;
        logic [63:0] pa;
        logic [15:0] capptag;
        logic [2:0]  pl;
        logic [2:0]  beats;
    } cmd_entry_t;

    function automatic logic [2:0] calc_beats(input logic [7:0] opcode, input logic [1:0] dl);
        logic [2:0] beats;
        beats = 3'd0;
        if (opcode == OPC_PR_WR_MEM) begin
            beats = 3'd1;
        end else if (opcode == OPC_WRITE_MEM || opcode == OPC_WRITE_MEM_BE) begin
            case (dl)
                2'b10:   beats = 3'd2;
                2'b11:   beats = 3'd4;
                default: beats = 3'd1;  // dl=00 is illegal; pull a single beat rather than hang
            endcase
        end
        return beats;
    endfunction

    function automatic logic [2:0] enc_rd_cnt(input logic [2:0] beats);
        logic [2:0] enc;
        case (beats)
            3'd2:    enc = RD_CNT_2;
            3'd4:    enc = RD_CNT_4;
            default: enc = RD_CNT_1;
        endcase
        return enc;
    endfunction

endpackage

// File: rtl/ocx_afu_cmd_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a pop in the same cycle frees the
// slot for a push even when full.
module ocx_afu_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/ocx_afu_cmd_intake.sv
// AFU-side TLX command intake: buffers commands, presents them to the engine,
// pulls and forwards write data, and returns one credit per retired command.
module ocx_afu_cmd_intake
    import ocx_afu_cmd_pkg::*;
#(
    parameter int CMD_FIFO_DEPTH = 8,
    parameter int INIT_CREDIT    = CMD_FIFO_DEPTH
) (
    input  logic         tlx_clk,
    input  logic         reset_n,
    input  logic         tlx_afu_ready,
    input  logic         tlx_afu_cmd_valid,
    input  logic [7:0]   tlx_afu_cmd_opcode,
    input  logic [1:0]   tlx_afu_cmd_dl,
    input  logic [63:0]  tlx_afu_cmd_pa,
    input  logic [15:0]  tlx_afu_cmd_capptag,
    input  logic [2:0]   tlx_afu_cmd_pl,
    input  logic         tlx_afu_cmd_data_valid,
    input  logic [511:0] tlx_afu_cmd_data_bus,
    input  logic         tlx_afu_cmd_data_bdi,
    output logic         afu_tlx_cmd_rd_req,
    output logic [2:0]   afu_tlx_cmd_rd_cnt,
    output logic         afu_tlx_cmd_credit,
    output logic [6:0]   afu_tlx_cmd_initial_credit,
    output logic         cmd_out_valid,
    input  logic         cmd_out_ready,
    output logic [7:0]   cmd_out_opcode,
    output logic [1:0]   cmd_out_dl,
    output logic [63:0]  cmd_out_pa,
    output logic [15:0]  cmd_out_capptag,
    output logic [2:0]   cmd_out_pl,
    output logic [2:0]   cmd_out_beats,
    output logic         data_out_valid,
    output logic [511:0] data_out_bus,
    output logic         data_out_bdi,
    output logic         intake_overflow,
    output logic         intake_bdi_seen
);
    state_e     state;
    state_e     state_nxt;
    cmd_entry_t push_entry;
    cmd_entry_t head;
    logic       push_req;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fwd;
    logic       stray_beat;
    logic [2:0] beat_cnt;
    logic       vld_p1;
    logic [511:0] data_bus_p1;
    logic       data_bdi_p1;
    logic       overflow_q;
    logic       bdi_seen_q;

    assign push_req   = tlx_afu_cmd_valid && tlx_afu_ready;
    assign push_entry = '{opcode:  tlx_afu_cmd_opcode,
                          dl:      tlx_afu_cmd_dl,
                          pa:      tlx_afu_cmd_pa,
                          capptag: tlx_afu_cmd_capptag,
                          pl:      tlx_afu_cmd_pl,
                          beats:   calc_beats(tlx_afu_cmd_opcode, tlx_afu_cmd_dl)};

    ocx_afu_cmd_fifo #(
        .DEPTH (CMD_FIFO_DEPTH),
        .WIDTH ($bits(cmd_entry_t))
    ) u_fifo (
        .clk   (tlx_clk),
        .rst_n (reset_n),
        .push  (push_req),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // IDLE also looks at the incoming push so the head is presented the cycle after it lands
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tlx_afu_ready && (!fifo_empty || push_req)) state_nxt = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (cmd_out_ready) begin
                    if (head.beats == 3'd0) begin
                        pop       = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_RDREQ;
                    end
                end
            end
            ST_RDREQ: state_nxt = ST_DATA;
            ST_DATA: begin
                if (tlx_afu_cmd_data_valid && beat_cnt == 3'd1) begin
                    pop       = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign fwd        = (state == ST_DATA) && tlx_afu_cmd_data_valid;
    assign stray_beat = (state != ST_DATA) && tlx_afu_cmd_data_valid;

    always_ff @(posedge tlx_clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            beat_cnt <= 3'd0;
        end else begin
            state <= state_nxt;
            if (state == ST_RDREQ) beat_cnt <= head.beats;
            else if (fwd)          beat_cnt <= beat_cnt - 3'd1;
        end
    end

    // stage p1: registered data forwarding and sticky status
    always_ff @(posedge tlx_clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1      <= 1'b0;
            data_bus_p1 <= '0;
            data_bdi_p1 <= 1'b0;
            overflow_q  <= 1'b0;
            bdi_seen_q  <= 1'b0;
        end else begin
            vld_p1 <= fwd;
            if (fwd) begin
                data_bus_p1 <= tlx_afu_cmd_data_bus;
                data_bdi_p1 <= tlx_afu_cmd_data_bdi;
            end
            if ((push_req && fifo_full && !pop) || stray_beat) overflow_q <= 1'b1;
            if (fwd && tlx_afu_cmd_data_bdi) bdi_seen_q <= 1'b1;
        end
    end

    assign cmd_out_valid   = (state == ST_PRESENT);
    assign cmd_out_opcode  = cmd_out_valid ? head.opcode  : '0;
    assign cmd_out_dl      = cmd_out_valid ? head.dl      : '0;
    assign cmd_out_pa      = cmd_out_valid ? head.pa      : '0;
    assign cmd_out_capptag = cmd_out_valid ? head.capptag : '0;
    assign cmd_out_pl      = cmd_out_valid ? head.pl      : '0;
    assign cmd_out_beats   = cmd_out_valid ? head.beats   : '0;

    assign afu_tlx_cmd_rd_req         = (state == ST_RDREQ);
    assign afu_tlx_cmd_rd_cnt         = afu_tlx_cmd_rd_req ? enc_rd_cnt(head.beats) : 3'd0;
    assign afu_tlx_cmd_credit         = pop;
    assign afu_tlx_cmd_initial_credit = 7'(INIT_CREDIT);

    assign data_out_valid  = vld_p1;
    assign data_out_bus    = data_bus_p1;
    assign data_out_bdi    = data_bdi_p1;
    assign intake_overflow = overflow_q;
    assign intake_bdi_seen = bdi_seen_q;

endmodule

// File: tb/tb_ocx_afu_cmd_intake.sv
// Scenario bench for ocx_afu_cmd_intake with a queue-based reference model.
module tb_ocx_afu_cmd_intake;
    localparam int DEPTH = 8;

    logic         tlx_clk = 1'b0;
    logic         reset_n;
    logic         tlx_afu_ready;
    logic         tlx_afu_cmd_valid;
    logic [7:0]   tlx_afu_cmd_opcode;
    logic [1:0]   tlx_afu_cmd_dl;
    logic [63:0]  tlx_afu_cmd_pa;
    logic [15:0]  tlx_afu_cmd_capptag;
    logic [2:0]   tlx_afu_cmd_pl;
    logic         tlx_afu_cmd_data_valid;
    logic [511:0] tlx_afu_cmd_data_bus;
    logic         tlx_afu_cmd_data_bdi;
    logic         afu_tlx_cmd_rd_req;
    logic [2:0]   afu_tlx_cmd_rd_cnt;
    logic         afu_tlx_cmd_credit;
    logic [6:0]   afu_tlx_cmd_initial_credit;
    logic         cmd_out_valid;
    logic         cmd_out_ready;
    logic [7:0]   cmd_out_opcode;
    logic [1:0]   cmd_out_dl;
    logic [63:0]  cmd_out_pa;
    logic [15:0]  cmd_out_capptag;
    logic [2:0]   cmd_out_pl;
    logic [2:0]   cmd_out_beats;
    logic         data_out_valid;
    logic [511:0] data_out_bus;
    logic         data_out_bdi;
    logic         intake_overflow;
    logic         intake_bdi_seen;

    ocx_afu_cmd_intake #(.CMD_FIFO_DEPTH(DEPTH)) dut (
        .tlx_clk                    (tlx_clk),
        .reset_n                    (reset_n),
        .tlx_afu_ready              (tlx_afu_ready),
        .tlx_afu_cmd_valid          (tlx_afu_cmd_valid),
        .tlx_afu_cmd_opcode         (tlx_afu_cmd_opcode),
        .tlx_afu_cmd_dl             (tlx_afu_cmd_dl),
        .tlx_afu_cmd_pa             (tlx_afu_cmd_pa),
        .tlx_afu_cmd_capptag        (tlx_afu_cmd_capptag),
        .tlx_afu_cmd_pl             (tlx_afu_cmd_pl),
        .tlx_afu_cmd_data_valid     (tlx_afu_cmd_data_valid),
        .tlx_afu_cmd_data_bus       (tlx_afu_cmd_data_bus),
        .tlx_afu_cmd_data_bdi       (tlx_afu_cmd_data_bdi),
        .afu_tlx_cmd_rd_req         (afu_tlx_cmd_rd_req),
        .afu_tlx_cmd_rd_cnt         (afu_tlx_cmd_rd_cnt),
        .afu_tlx_cmd_credit         (afu_tlx_cmd_credit),
        .afu_tlx_cmd_initial_credit (afu_tlx_cmd_initial_credit),
        .cmd_out_valid              (cmd_out_valid),
        .cmd_out_ready              (cmd_out_ready),
        .cmd_out_opcode             (cmd_out_opcode),
        .cmd_out_dl                 (cmd_out_dl),
        .cmd_out_pa                 (cmd_out_pa),
        .cmd_out_capptag            (cmd_out_capptag),
        .cmd_out_pl                 (cmd_out_pl),
        .cmd_out_beats              (cmd_out_beats),
        .data_out_valid             (data_out_valid),
        .data_out_bus               (data_out_bus),
        .data_out_bdi               (data_out_bdi),
        .intake_overflow            (intake_overflow),
        .intake_bdi_seen            (intake_bdi_seen)
    );

    always #5 tlx_clk = ~tlx_clk;

    typedef struct {
        logic [7:0]  op;
        logic [1:0]  dl;
        logic [63:0] pa;
        logic [15:0] tag;
        logic [2:0]  pl;
        int          beats;
    } cmd_t;

    int pass_cnt  = 0;
    int check_cnt = 0;

    // observation side, sampled on the falling edge
    int           credit_cnt = 0;
    int           rdreq_cnt  = 0;
    int           req_beats  = 0;
    logic [2:0]   rdcnt_q[$];
    logic [512:0] data_q[$];
    cmd_t         acc_q[$];

    // reference side
    cmd_t         exp_q[$];
    logic [512:0] exp_data_q[$];

    initial begin
        cmd_t mc;
        forever begin
            @(negedge tlx_clk);
            if (afu_tlx_cmd_credit === 1'b1) credit_cnt++;
            if (afu_tlx_cmd_rd_req === 1'b1) begin
                rdreq_cnt++;
                rdcnt_q.push_back(afu_tlx_cmd_rd_cnt);
                req_beats += (afu_tlx_cmd_rd_cnt == 3'b100) ? 4 : (afu_tlx_cmd_rd_cnt == 3'b010) ? 2 : 1;
            end
            if (data_out_valid === 1'b1) data_q.push_back({data_out_bdi, data_out_bus});
            if (cmd_out_valid === 1'b1 && cmd_out_ready === 1'b1) begin
                mc.op    = cmd_out_opcode;
                mc.dl    = cmd_out_dl;
                mc.pa    = cmd_out_pa;
                mc.tag   = cmd_out_capptag;
                mc.pl    = cmd_out_pl;
                mc.beats = int'({29'd0, cmd_out_beats});
                acc_q.push_back(mc);
            end
        end
    end

    function automatic int model_beats(input logic [7:0] op, input logic [1:0] dl);
        if (op == 8'h86) return 1;
        if (op == 8'h81 || op == 8'h82) return (dl == 2'b11) ? 4 : (dl == 2'b10) ? 2 : 1;
        return 0;
    endfunction

    function automatic logic [2:0] model_rd_cnt(input int beats);
        return (beats == 4) ? 3'b100 : (beats == 2) ? 3'b010 : 3'b001;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic tick();
        @(posedge tlx_clk);
        #1;
    endtask

    task automatic push_cmd(input logic [7:0] op, input logic [1:0] dl, input logic [15:0] tag);
        tlx_afu_cmd_valid   = 1'b1;
        tlx_afu_cmd_opcode  = op;
        tlx_afu_cmd_dl      = dl;
        tlx_afu_cmd_pa      = {$urandom(), $urandom()};
        tlx_afu_cmd_capptag = tag;
        tlx_afu_cmd_pl      = 3'($urandom_range(0, 7));
        tick();
        tlx_afu_cmd_valid   = 1'b0;
    endtask

    task automatic test_reset_state();
        logic [17:0] outs;
        outs = {cmd_out_valid, afu_tlx_cmd_credit, afu_tlx_cmd_rd_req, afu_tlx_cmd_rd_cnt, data_out_valid,
                data_out_bdi, intake_overflow, intake_bdi_seen, cmd_out_opcode};
        check_cnt++;
        if (outs !== '0) $display("FAIL reset_outputs: got %h want 0", outs);
        else pass_cnt++;
        check_cnt++;
        if (afu_tlx_cmd_initial_credit !== 7'd8)
            $display("FAIL reset_init_credit: got %0d want 8", afu_tlx_cmd_initial_credit);
        else pass_cnt++;
        reset_n = 1'b1;
        tick();
        tick();
        check_cnt++;
        if (cmd_out_valid !== 1'b0) $display("FAIL reset_idle_valid: got %b want 0", cmd_out_valid);
        else pass_cnt++;
    endtask

    task automatic test_read_cmd();
        int c0 = credit_cnt;
        int r0 = rdreq_cnt;
        cmd_out_ready = 1'b1;
        push_cmd(8'h20, 2'b00, 16'h1234);
        check_cnt++;
        if (cmd_out_valid !== 1'b1 || cmd_out_capptag !== 16'h1234 || cmd_out_opcode !== 8'h20)
            $display("FAIL read_present: valid=%b tag=%h op=%h want 1/1234/20", cmd_out_valid, cmd_out_capptag, cmd_out_opcode);
        else pass_cnt++;
        check_cnt++;
        if (cmd_out_beats !== 3'd0 || afu_tlx_cmd_credit !== 1'b1)
            $display("FAIL read_accept: beats=%0d credit=%b want 0/1", cmd_out_beats, afu_tlx_cmd_credit);
        else pass_cnt++;
        tick();
        check_cnt++;
        if (cmd_out_valid !== 1'b0 || afu_tlx_cmd_credit !== 1'b0)
            $display("FAIL read_retired: valid=%b credit=%b want 0/0", cmd_out_valid, afu_tlx_cmd_credit);
        else pass_cnt++;
        tick();
        tick();
        check_cnt++;
        if (credit_cnt - c0 != 1 || rdreq_cnt - r0 != 0)
            $display("FAIL read_counts: credits=%0d rdreqs=%0d want 1/0", credit_cnt - c0, rdreq_cnt - r0);
        else pass_cnt++;
    endtask

    task automatic test_write_256();
        logic [511:0] beat [4];
        int c0 = credit_cnt;
        int r0 = rdreq_cnt;
        for (int i = 0; i < 4; i++) beat[i] = rand512();
        cmd_out_ready = 1'b1;
        push_cmd(8'h81, 2'b11, 16'h0256);
        check_cnt++;
        if (cmd_out_valid !== 1'b1 || cmd_out_beats !== 3'd4 || afu_tlx_cmd_credit !== 1'b0)
            $display("FAIL wr256_present: valid=%b beats=%0d credit=%b want 1/4/0", cmd_out_valid, cmd_out_beats, afu_tlx_cmd_credit);
        else pass_cnt++;
        tick();
        check_cnt++;
        if (afu_tlx_cmd_rd_req !== 1'b1 || afu_tlx_cmd_rd_cnt !== 3'b100)
            $display("FAIL wr256_rdreq: req=%b cnt=%b want 1/100", afu_tlx_cmd_rd_req, afu_tlx_cmd_rd_cnt);
        else pass_cnt++;
        tick();
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            tlx_afu_cmd_data_valid = 1'b1;
            tlx_afu_cmd_data_bus   = beat[i];
            tlx_afu_cmd_data_bdi   = 1'b0;
            #1;
            check_cnt++;
            if (afu_tlx_cmd_credit !== (i == 3))
                $display("FAIL wr256_credit_beat%0d: got %b want %b", i, afu_tlx_cmd_credit, (i == 3));
            else pass_cnt++;
            tick();
            tlx_afu_cmd_data_valid = 1'b0;
            check_cnt++;
            if (data_out_valid !== 1'b1 || data_out_bus !== beat[i])
                $display("FAIL wr256_beat%0d: valid=%b bus_lo=%h want 1/%h", i, data_out_valid, data_out_bus[31:0], beat[i][31:0]);
            else pass_cnt++;
        end
        tick();
        check_cnt++;
        if (data_out_valid !== 1'b0 || credit_cnt - c0 != 1 || rdreq_cnt - r0 != 1)
            $display("FAIL wr256_end: dvalid=%b credits=%0d rdreqs=%0d want 0/1/1", data_out_valid, credit_cnt - c0, rdreq_cnt - r0);
        else pass_cnt++;
    endtask

    task automatic test_pr_wr_bdi();
        logic [511:0] b = rand512();
        cmd_out_ready = 1'b1;
        push_cmd(8'h86, 2'b11, 16'h0086);
        check_cnt++;
        if (cmd_out_beats !== 3'd1) $display("FAIL prwr_beats: got %0d want 1", cmd_out_beats);
        else pass_cnt++;
        tick();
        check_cnt++;
        if (afu_tlx_cmd_rd_req !== 1'b1 || afu_tlx_cmd_rd_cnt !== 3'b001)
            $display("FAIL prwr_rdcnt: req=%b cnt=%b want 1/001", afu_tlx_cmd_rd_req, afu_tlx_cmd_rd_cnt);
        else pass_cnt++;
        tick();
        tlx_afu_cmd_data_valid = 1'b1;
        tlx_afu_cmd_data_bus   = b;
        tlx_afu_cmd_data_bdi   = 1'b1;
        #1;
        check_cnt++;
        if (afu_tlx_cmd_credit !== 1'b1) $display("FAIL prwr_credit: got %b want 1", afu_tlx_cmd_credit);
        else pass_cnt++;
        tick();
        tlx_afu_cmd_data_valid = 1'b0;
        tlx_afu_cmd_data_bdi   = 1'b0;
        check_cnt++;
        if (data_out_valid !== 1'b1 || data_out_bdi !== 1'b1 || intake_bdi_seen !== 1'b1 || data_out_bus !== b)
            $display("FAIL prwr_bdi: valid=%b bdi=%b seen=%b want 1/1/1", data_out_valid, data_out_bdi, intake_bdi_seen);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_overflow();
        int c0 = credit_cnt;
        cmd_out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            push_cmd(8'h20, 2'b00, 16'h0100 + 16'(i));
            if (i == 7) begin
                check_cnt++;
                if (intake_overflow !== 1'b0) $display("FAIL ovf_at_8: got %b want 0", intake_overflow);
                else pass_cnt++;
            end
        end
        check_cnt++;
        if (intake_overflow !== 1'b1 || credit_cnt != c0)
            $display("FAIL ovf_at_9: ovf=%b credits=%0d want 1/0", intake_overflow, credit_cnt - c0);
        else pass_cnt++;
        acc_q.delete();
        cmd_out_ready = 1'b1;
        repeat (40) tick();
        cmd_out_ready = 1'b0;
        check_cnt++;
        if (credit_cnt - c0 != 8 || acc_q.size() != 8)
            $display("FAIL ovf_drain: credits=%0d accepted=%0d want 8/8", credit_cnt - c0, acc_q.size());
        else pass_cnt++;
        for (int i = 0; i < acc_q.size() && i < 8; i++) begin
            check_cnt++;
            if (acc_q[i].tag !== 16'h0100 + 16'(i))
                $display("FAIL ovf_order%0d: got %h want %h", i, acc_q[i].tag, 16'h0100 + 16'(i));
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        logic [17:0] outs;
        int c0;
        check_cnt++;
        if (intake_overflow !== 1'b1 || intake_bdi_seen !== 1'b1)
            $display("FAIL rst_pre_sticky: ovf=%b bdi=%b want 1/1", intake_overflow, intake_bdi_seen);
        else pass_cnt++;
        cmd_out_ready = 1'b0;
        push_cmd(8'h81, 2'b10, 16'h0301);
        push_cmd(8'h20, 2'b00, 16'h0302);
        push_cmd(8'h20, 2'b00, 16'h0303);
        #2;
        reset_n = 1'b0;
        #1;
        outs = {cmd_out_valid, afu_tlx_cmd_credit, afu_tlx_cmd_rd_req, afu_tlx_cmd_rd_cnt, data_out_valid,
                data_out_bdi, intake_overflow, intake_bdi_seen, cmd_out_opcode};
        check_cnt++;
        if (outs !== '0) $display("FAIL rst_async_outputs: got %h want 0", outs);
        else pass_cnt++;
        check_cnt++;
        if (afu_tlx_cmd_initial_credit !== 7'd8)
            $display("FAIL rst_init_credit: got %0d want 8", afu_tlx_cmd_initial_credit);
        else pass_cnt++;
        cmd_out_ready = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        c0 = credit_cnt;
        repeat (5) tick();
        check_cnt++;
        if (credit_cnt != c0 || cmd_out_valid !== 1'b0)
            $display("FAIL rst_no_credit: credits=%0d valid=%b want 0/0", credit_cnt - c0, cmd_out_valid);
        else pass_cnt++;
        cmd_out_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        int c0;
        cmd_out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_cmd(8'h20, 2'b00, 16'h0200 + 16'(i));
        check_cnt++;
        if (intake_overflow !== 1'b0) $display("FAIL fpp_fill: ovf=%b want 0", intake_overflow);
        else pass_cnt++;
        acc_q.delete();
        c0 = credit_cnt;
        cmd_out_ready = 1'b1;
        push_cmd(8'h20, 2'b00, 16'h0208);
        cmd_out_ready = 1'b0;
        check_cnt++;
        if (intake_overflow !== 1'b0) $display("FAIL fpp_same_cycle: ovf=%b want 0", intake_overflow);
        else pass_cnt++;
        push_cmd(8'h20, 2'b00, 16'h0209);
        check_cnt++;
        if (intake_overflow !== 1'b1) $display("FAIL fpp_still_full: ovf=%b want 1", intake_overflow);
        else pass_cnt++;
        cmd_out_ready = 1'b1;
        repeat (40) tick();
        cmd_out_ready = 1'b0;
        check_cnt++;
        if (credit_cnt - c0 != 9 || acc_q.size() != 9)
            $display("FAIL fpp_drain: credits=%0d accepted=%0d want 9/9", credit_cnt - c0, acc_q.size());
        else pass_cnt++;
        for (int i = 0; i < acc_q.size() && i < 9; i++) begin
            check_cnt++;
            if (acc_q[i].tag !== 16'h0200 + 16'(i))
                $display("FAIL fpp_order%0d: got %h want %h", i, acc_q[i].tag, 16'h0200 + 16'(i));
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [7:0]   ops [6];
        logic [2:0]   exp_cnt[$];
        logic [512:0] d;
        cmd_t         c;
        int n_cmd = 60;
        int sent = 0;
        int drv_beats = 0;
        int cyc = 0;
        int c0;
        ops = '{8'h81, 8'h82, 8'h86, 8'h20, 8'h28, 8'h01};
        exp_q.delete();
        exp_data_q.delete();
        acc_q.delete();
        data_q.delete();
        rdcnt_q.delete();
        req_beats = 0;
        c0 = credit_cnt;
        while (!(sent == n_cmd && credit_cnt - c0 == n_cmd) && cyc < 4000) begin
            tlx_afu_cmd_valid      = 1'b0;
            tlx_afu_cmd_data_valid = 1'b0;
            if (sent < n_cmd && (sent - (credit_cnt - c0)) < DEPTH && $urandom_range(0, 2) != 0) begin
                c.op    = ops[$urandom_range(0, 5)];
                c.dl    = 2'($urandom_range(0, 3));
                c.pa    = {$urandom(), $urandom()};
                c.tag   = 16'($urandom());
                c.pl    = 3'($urandom_range(0, 7));
                c.beats = model_beats(c.op, c.dl);
                tlx_afu_cmd_valid   = 1'b1;
                tlx_afu_cmd_opcode  = c.op;
                tlx_afu_cmd_dl      = c.dl;
                tlx_afu_cmd_pa      = c.pa;
                tlx_afu_cmd_capptag = c.tag;
                tlx_afu_cmd_pl      = c.pl;
                exp_q.push_back(c);
                sent++;
            end
            cmd_out_ready = ($urandom_range(0, 3) != 0);
            if (req_beats > drv_beats && $urandom_range(0, 2) != 0) begin
                d = {($urandom_range(0, 7) == 0), rand512()};
                tlx_afu_cmd_data_valid = 1'b1;
                tlx_afu_cmd_data_bdi   = d[512];
                tlx_afu_cmd_data_bus   = d[511:0];
                exp_data_q.push_back(d);
                drv_beats++;
            end
            tick();
            cyc++;
        end
        tlx_afu_cmd_valid      = 1'b0;
        tlx_afu_cmd_data_valid = 1'b0;
        cmd_out_ready          = 1'b0;
        tick();
        tick();
        check_cnt++;
        if (credit_cnt - c0 != n_cmd)
            $display("FAIL rnd_credits: got %0d want %0d after %0d cycles", credit_cnt - c0, n_cmd, cyc);
        else pass_cnt++;
        check_cnt++;
        if (acc_q.size() != exp_q.size())
            $display("FAIL rnd_accept_count: got %0d want %0d", acc_q.size(), exp_q.size());
        else pass_cnt++;
        for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++) begin
            check_cnt++;
            if (acc_q[i].op !== exp_q[i].op || acc_q[i].dl !== exp_q[i].dl || acc_q[i].pa !== exp_q[i].pa ||
                acc_q[i].tag !== exp_q[i].tag || acc_q[i].pl !== exp_q[i].pl || acc_q[i].beats != exp_q[i].beats)
                $display("FAIL rnd_cmd%0d: got op=%h tag=%h beats=%0d want op=%h tag=%h beats=%0d", i,
                         acc_q[i].op, acc_q[i].tag, acc_q[i].beats, exp_q[i].op, exp_q[i].tag, exp_q[i].beats);
            else pass_cnt++;
        end
        foreach (exp_q[i]) if (exp_q[i].beats > 0) exp_cnt.push_back(model_rd_cnt(exp_q[i].beats));
        check_cnt++;
        if (rdcnt_q.size() != exp_cnt.size())
            $display("FAIL rnd_rdreq_count: got %0d want %0d", rdcnt_q.size(), exp_cnt.size());
        else pass_cnt++;
        for (int i = 0; i < rdcnt_q.size() && i < exp_cnt.size(); i++) begin
            check_cnt++;
            if (rdcnt_q[i] !== exp_cnt[i]) $display("FAIL rnd_rdcnt%0d: got %b want %b", i, rdcnt_q[i], exp_cnt[i]);
            else pass_cnt++;
        end
        check_cnt++;
        if (data_q.size() != exp_data_q.size())
            $display("FAIL rnd_beat_count: got %0d want %0d", data_q.size(), exp_data_q.size());
        else pass_cnt++;
        for (int i = 0; i < data_q.size() && i < exp_data_q.size(); i++) begin
            check_cnt++;
            if (data_q[i] !== exp_data_q[i])
                $display("FAIL rnd_beat%0d: got bdi=%b lo=%h want bdi=%b lo=%h", i, data_q[i][512], data_q[i][31:0],
                         exp_data_q[i][512], exp_data_q[i][31:0]);
            else pass_cnt++;
        end
    endtask

    initial begin
        reset_n                = 1'b0;
        tlx_afu_ready          = 1'b1;
        tlx_afu_cmd_valid      = 1'b0;
        tlx_afu_cmd_opcode     = '0;
        tlx_afu_cmd_dl         = '0;
        tlx_afu_cmd_pa         = '0;
        tlx_afu_cmd_capptag    = '0;
        tlx_afu_cmd_pl         = '0;
        tlx_afu_cmd_data_valid = 1'b0;
        tlx_afu_cmd_data_bus   = '0;
        tlx_afu_cmd_data_bdi   = 1'b0;
        cmd_out_ready          = 1'b0;
        repeat (3) tick();
        test_reset_state();
        test_read_cmd();
        test_write_256();
        test_pr_wr_bdi();
        test_overflow();
        test_reset();
        test_full_push_pop();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
